// File: rtl/v_lane_mem_ctrl.sv
// Moves one strided vector load or store between external memory and a single
// lane's load/store FIFOs, keeping a bounded number of reads in flight.
module v_lane_mem_ctrl #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int VECTOR_LENGTH   = 32,
  parameter int MAX_OUTSTANDING = 4,
  localparam int VL_W = $clog2(VECTOR_LENGTH * 8) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic                  is_store_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH-1:0] stride_i,
  input  logic [VL_W-1:0]       vector_length_i,
  output logic                  ready_o,
  output logic                  done_o,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  load_fifo_we_o,
  output logic [DATA_WIDTH-1:0] load_fifo_wdata_o,
  input  logic                  load_fifo_almostfull_i,
  output logic                  store_fifo_re_o,
  input  logic [DATA_WIDTH-1:0] store_fifo_dout_i,
  input  logic                  store_fifo_empty_i
);

  typedef enum logic [2:0] {
    IDLE, LD_ISSUE, LD_DRAIN, ST_FETCH, ST_CAPT, ST_REQ, DONE
  } state_t;

  state_t state, next_state;

  logic [VL_W-1:0]       vl_q, issued, received, outstanding;
  logic [ADDR_WIDTH-1:0] addr, stride_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  pending;     // load request shown but not yet accepted
  logic                  req_valid, handshake, can_issue, ret, last_req;

  assign outstanding = issued - received;
  assign can_issue   = (issued < vl_q) && (outstanding < VL_W'(MAX_OUTSTANDING))
                       && !load_fifo_almostfull_i;
  assign ret         = mem_rvalid_i && (state == LD_ISSUE || state == LD_DRAIN);
  assign last_req    = (issued + VL_W'(1)) == vl_q;
  assign handshake   = req_valid && mem_req_ready_i;

  assign mem_req_valid_o = req_valid;
  assign mem_addr_o      = req_valid ? addr : '0;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    // NOTE: default first so every path assigns next_state and no latch is inferred.
    next_state = state;
    unique case (state)
      IDLE: if (start_i) begin
        if (vector_length_i == '0) next_state = DONE;
        else if (is_store_i)       next_state = ST_FETCH;
        else                       next_state = LD_ISSUE;
      end
      LD_ISSUE: if (handshake && last_req) next_state = LD_DRAIN;
      LD_DRAIN: if (received == vl_q)      next_state = DONE;
      ST_FETCH: if (!store_fifo_empty_i)   next_state = ST_CAPT;
      ST_CAPT:  next_state = ST_REQ;
      ST_REQ:   if (handshake) next_state = last_req ? DONE : ST_FETCH;
      DONE:     next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_comb begin
    ready_o         = 1'b0;
    done_o          = 1'b0;
    req_valid       = 1'b0;
    mem_we_o        = 1'b0;
    mem_wdata_o     = '0;
    store_fifo_re_o = 1'b0;
    unique case (state)
      IDLE:     ready_o = 1'b1;
      // Once raised, a load request is held by pending even if almostfull rises.
      LD_ISSUE: req_valid = pending || can_issue;
      ST_FETCH: store_fifo_re_o = !store_fifo_empty_i;
      ST_REQ: begin
        req_valid   = 1'b1;
        mem_we_o    = 1'b1;
        mem_wdata_o = wdata_q;
      end
      DONE:     done_o = 1'b1;
      default:  ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      vl_q              <= '0;
      stride_q          <= '0;
      addr              <= '0;
      issued            <= '0;
      received          <= '0;
      pending           <= 1'b0;
      wdata_q           <= '0;
      load_fifo_we_o    <= 1'b0;
      load_fifo_wdata_o <= '0;
    end else begin
      load_fifo_we_o <= ret;
      if (ret) load_fifo_wdata_o <= mem_rdata_i;
      pending <= (state == LD_ISSUE) && req_valid && !mem_req_ready_i;
      if (state == ST_CAPT) wdata_q <= store_fifo_dout_i;
      if (state == IDLE) begin
        if (start_i) begin
          vl_q     <= vector_length_i;
          stride_q <= stride_i;
          addr     <= base_addr_i;
          issued   <= '0;
          received <= '0;
        end
      end else begin
        // Address of element k accumulates to base + k*stride, wrapping naturally.
        if (handshake) begin
          issued <= issued + VL_W'(1);
          addr   <= addr + stride_q;
        end
        if (ret) received <= received + VL_W'(1);
      end
    end
  end

endmodule
